// File: rtl/memory_access_if.sv
// Data-memory bus between the memory_access stage (master) and data memory (slave).
interface memory_access_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ready;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
      input  mem_ready, mem_rvalid, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
      output mem_ready, mem_rvalid, mem_rdata
   );
endinterface

// File: rtl/memory_access.sv
// Memory stage: drives the data-memory handshake, steers store lanes, extends loads,
// and registers write-back and forwarding outputs. Stalls upstream while an access is open.
module memory_access #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [31:0]            result_input,
   input  logic [31:0]            rs2_value_input,
   input  logic [31:0]            pc_input,
   input  logic [1:0]             read_status_input,
   input  logic [1:0]             write_status_input,
   input  logic                   load_signed_input,
   input  logic [4:0]             destination_register_number_input,
   input  logic [1:0]             write_back_type_input,
   memory_access_if.master        mem_bus,
   output logic                   stall,
   output logic [31:0]            pc_output,
   output logic [31:0]            write_back_value,
   output logic [4:0]             destination_register_number_output,
   output logic [1:0]             write_back_type_output,
   output logic [31:0]            value_forward,
   output logic [4:0]             register_forward,
   output logic                   forward_enable,
   output logic                   misaligned,
   output logic                   bus_error
);

   localparam logic [1:0] WB_NORMAL = 2'b01;
   localparam logic [1:0] WB_HICCUP = 2'b11;
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {StIdle, StAccess, StWaitData, StComplete} state_e;

   state_e          r_state, w_state_d;
   logic [TW-1:0]   r_timeout, w_timeout_d;

   // Operation latched at the start of an access
   logic [31:0] r_addr, r_rs2, r_pc, r_rdata;
   logic [1:0]  r_size, r_wbt;
   logic        r_is_load, r_signed;
   logic [4:0]  r_rd;

   logic [31:0] r_pc_out, r_wbv, r_val_fwd;
   logic [4:0]  r_rd_out, r_reg_fwd;
   logic [1:0]  r_wbt_out;
   logic        r_fwd_en, r_misaligned, r_bus_error;

   logic        w_latch, w_capture;
   logic [31:0] w_pc_d, w_wbv_d;
   logic [4:0]  w_rd_d;
   logic [1:0]  w_wbt_d;
   logic        w_misaligned_d, w_bus_error_d, w_fwd_en_d;

   logic        w_in_load, w_in_store, w_bubble, w_mem_op, w_in_misaligned;
   logic [1:0]  w_in_size;
   logic        w_timeout_hit, w_in_access;
   logic [7:0]  w_ld_byte;
   logic [15:0] w_ld_half;
   logic [31:0] w_ld_value, w_wdata;
   logic [3:0]  w_wstrb;

   // A load takes precedence when both read and write status are set
   assign w_in_load  = |read_status_input;
   assign w_in_store = (|write_status_input) & ~w_in_load;
   assign w_in_size  = w_in_load ? read_status_input : write_status_input;
   assign w_bubble   = (write_back_type_input == WB_HICCUP);
   assign w_mem_op   = ~w_bubble & (w_in_load | w_in_store);
   assign w_in_misaligned = ((w_in_size == 2'b10) & result_input[0]) |
                            ((w_in_size == 2'b11) & (|result_input[1:0]));

   assign w_timeout_hit = (r_timeout >= TW'(TIMEOUT_CYCLES - 1));

   assign w_ld_byte = r_rdata[{r_addr[1:0], 3'b000} +: 8];
   assign w_ld_half = r_rdata[{r_addr[1], 4'b0000} +: 16];

   always_comb begin
      w_ld_value = r_rdata;
      case (r_size)
         2'b01:   w_ld_value = {{24{r_signed & w_ld_byte[7]}}, w_ld_byte};
         2'b10:   w_ld_value = {{16{r_signed & w_ld_half[15]}}, w_ld_half};
         default: w_ld_value = r_rdata;
      endcase
   end

   always_comb begin
      w_wdata = r_rs2;
      w_wstrb = 4'b1111;
      case (r_size)
         2'b01: begin
            w_wdata = {4{r_rs2[7:0]}};
            w_wstrb = 4'b0001 << r_addr[1:0];
         end
         2'b10: begin
            w_wdata = {2{r_rs2[15:0]}};
            w_wstrb = 4'b0011 << r_addr[1:0];
         end
         default: ;
      endcase
      if (r_is_load) w_wstrb = 4'b0000;
   end

   assign w_in_access       = (r_state == StAccess);
   assign mem_bus.mem_req   = w_in_access;
   assign mem_bus.mem_we    = w_in_access & ~r_is_load;
   assign mem_bus.mem_addr  = w_in_access ? {r_addr[31:2], 2'b00} : 32'h0;
   assign mem_bus.mem_wdata = w_in_access ? w_wdata : 32'h0;
   assign mem_bus.mem_wstrb = w_in_access ? w_wstrb : 4'b0000;

   always_comb begin
      w_state_d      = r_state;
      w_timeout_d    = r_timeout;
      w_latch        = 1'b0;
      w_capture      = 1'b0;
      w_pc_d         = r_pc_out;
      w_wbv_d        = r_wbv;
      w_rd_d         = r_rd_out;
      w_wbt_d        = r_wbt_out;
      w_misaligned_d = 1'b0;
      w_bus_error_d  = 1'b0;
      unique case (r_state)
         StIdle: begin
            w_timeout_d = '0;
            if (w_mem_op && w_in_misaligned) begin
               w_wbt_d        = WB_HICCUP;
               w_misaligned_d = 1'b1;
            end else if (w_mem_op) begin
               w_latch   = 1'b1;
               w_wbt_d   = WB_HICCUP;
               w_state_d = StAccess;
            end else begin
               w_pc_d  = pc_input;
               w_wbv_d = result_input;
               w_rd_d  = destination_register_number_input;
               w_wbt_d = write_back_type_input;
            end
         end
         StAccess: begin
            w_timeout_d = r_timeout + TW'(1);
            if (mem_bus.mem_ready) begin
               if (!r_is_load) begin
                  w_state_d = StComplete;
               end else if (mem_bus.mem_rvalid) begin
                  w_capture = 1'b1;
                  w_state_d = StComplete;
               end else begin
                  w_state_d = StWaitData;
               end
            end else if (w_timeout_hit) begin
               w_timeout_d   = '0;
               w_bus_error_d = 1'b1;
               w_wbt_d       = WB_HICCUP;
               w_state_d     = StIdle;
            end
         end
         StWaitData: begin
            w_timeout_d = r_timeout + TW'(1);
            if (mem_bus.mem_rvalid) begin
               w_capture = 1'b1;
               w_state_d = StComplete;
            end else if (w_timeout_hit) begin
               w_timeout_d   = '0;
               w_bus_error_d = 1'b1;
               w_wbt_d       = WB_HICCUP;
               w_state_d     = StIdle;
            end
         end
         StComplete: begin
            w_timeout_d = '0;
            w_state_d   = StIdle;
            w_pc_d      = r_pc;
            w_rd_d      = r_rd;
            w_wbt_d     = r_wbt;
            w_wbv_d     = r_is_load ? w_ld_value : r_addr;
         end
         default: w_state_d = StIdle;
      endcase
      w_fwd_en_d = (w_wbt_d == WB_NORMAL) && (w_rd_d != 5'd0);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= StIdle;
         r_timeout <= '0;
      end else begin
         r_state   <= w_state_d;
         r_timeout <= w_timeout_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_addr       <= '0;
         r_rs2        <= '0;
         r_pc         <= '0;
         r_rdata      <= '0;
         r_size       <= '0;
         r_wbt        <= '0;
         r_is_load    <= 1'b0;
         r_signed     <= 1'b0;
         r_rd         <= '0;
         r_pc_out     <= '0;
         r_wbv        <= '0;
         r_val_fwd    <= '0;
         r_rd_out     <= '0;
         r_reg_fwd    <= '0;
         r_wbt_out    <= WB_HICCUP;
         r_fwd_en     <= 1'b0;
         r_misaligned <= 1'b0;
         r_bus_error  <= 1'b0;
      end else begin
         if (w_latch) begin
            r_addr    <= result_input;
            r_rs2     <= rs2_value_input;
            r_pc      <= pc_input;
            r_size    <= w_in_size;
            r_wbt     <= write_back_type_input;
            r_is_load <= w_in_load;
            r_signed  <= load_signed_input;
            r_rd      <= destination_register_number_input;
         end
         if (w_capture) r_rdata <= mem_bus.mem_rdata;
         r_pc_out     <= w_pc_d;
         r_wbv        <= w_wbv_d;
         r_val_fwd    <= w_wbv_d;
         r_rd_out     <= w_rd_d;
         r_reg_fwd    <= w_rd_d;
         r_wbt_out    <= w_wbt_d;
         r_fwd_en     <= w_fwd_en_d;
         r_misaligned <= w_misaligned_d;
         r_bus_error  <= w_bus_error_d;
      end
   end

   assign stall                              = (r_state != StIdle);
   assign pc_output                          = r_pc_out;
   assign write_back_value                   = r_wbv;
   assign destination_register_number_output = r_rd_out;
   assign write_back_type_output             = r_wbt_out;
   assign value_forward                      = r_val_fwd;
   assign register_forward                   = r_reg_fwd;
   assign forward_enable                     = r_fwd_en;
   assign misaligned                         = r_misaligned;
   assign bus_error                          = r_bus_error;

endmodule

// File: tb/tb_memory_access.sv
// Directed self-checking bench for memory_access with hand-computed expected values.
module tb_memory_access;
   localparam logic [1:0] WB_NORMAL = 2'b01;
   localparam logic [1:0] WB_HICCUP = 2'b11;

   logic        clk;
   logic        reset;
   logic [31:0] result_input, rs2_value_input, pc_input;
   logic [1:0]  read_status_input, write_status_input, write_back_type_input;
   logic        load_signed_input;
   logic [4:0]  destination_register_number_input;
   logic        stall, forward_enable, misaligned, bus_error;
   logic [31:0] pc_output, write_back_value, value_forward;
   logic [4:0]  destination_register_number_output, register_forward;
   logic [1:0]  write_back_type_output;

   int n_checks = 0;
   int n_fail   = 0;

   memory_access_if mem_if ();

   memory_access #(
      .TIMEOUT_CYCLES(4)
   ) u_dut (
      .clk                                (clk),
      .reset                              (reset),
      .result_input                       (result_input),
      .rs2_value_input                    (rs2_value_input),
      .pc_input                           (pc_input),
      .read_status_input                  (read_status_input),
      .write_status_input                 (write_status_input),
      .load_signed_input                  (load_signed_input),
      .destination_register_number_input  (destination_register_number_input),
      .write_back_type_input              (write_back_type_input),
      .mem_bus                            (mem_if),
      .stall                              (stall),
      .pc_output                          (pc_output),
      .write_back_value                   (write_back_value),
      .destination_register_number_output (destination_register_number_output),
      .write_back_type_output             (write_back_type_output),
      .value_forward                      (value_forward),
      .register_forward                   (register_forward),
      .forward_enable                     (forward_enable),
      .misaligned                         (misaligned),
      .bus_error                          (bus_error)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_bubble();
      result_input                      = 32'h0;
      rs2_value_input                   = 32'h0;
      pc_input                          = 32'h0;
      read_status_input                 = 2'b00;
      write_status_input                = 2'b00;
      load_signed_input                 = 1'b0;
      destination_register_number_input = 5'd0;
      write_back_type_input             = WB_HICCUP;
   endtask

   task automatic set_op(input logic [31:0] pc, input logic [31:0] res, input logic [31:0] rs2,
                         input logic [1:0] rd_st, input logic [1:0] wr_st, input logic sgn,
                         input logic [4:0] rd);
      pc_input                          = pc;
      result_input                      = res;
      rs2_value_input                   = rs2;
      read_status_input                 = rd_st;
      write_status_input                = wr_st;
      load_signed_input                 = sgn;
      destination_register_number_input = rd;
      write_back_type_input             = WB_NORMAL;
   endtask

   initial begin
      reset             = 1'b1;
      mem_if.mem_ready  = 1'b0;
      mem_if.mem_rvalid = 1'b0;
      mem_if.mem_rdata  = 32'h0;
      set_bubble();
      #3;
      check_eq("reset_stall", 32'(stall), 32'd0);
      check_eq("reset_req", 32'(mem_if.mem_req), 32'd0);
      check_eq("reset_wbt", 32'(write_back_type_output), 32'(WB_HICCUP));
      check_eq("reset_wbv", write_back_value, 32'h0);
      check_eq("reset_fwd_en", 32'(forward_enable), 32'd0);
      step();
      reset = 1'b0;

      // ALU pass-through
      set_op(32'h40, 32'h1234, 32'h0, 2'b00, 2'b00, 1'b0, 5'd5);
      check_eq("alu_stall_pre", 32'(stall), 32'd0);
      step();
      check_eq("alu_wbv", write_back_value, 32'h1234);
      check_eq("alu_vfwd", value_forward, 32'h1234);
      check_eq("alu_rd", 32'(destination_register_number_output), 32'd5);
      check_eq("alu_rfwd", 32'(register_forward), 32'd5);
      check_eq("alu_pc", pc_output, 32'h40);
      check_eq("alu_fwd_en", 32'(forward_enable), 32'd1);
      check_eq("alu_stall", 32'(stall), 32'd0);
      set_bubble();
      step();
      check_eq("bubble_wbt", 32'(write_back_type_output), 32'(WB_HICCUP));
      check_eq("bubble_fwd_en", 32'(forward_enable), 32'd0);

      // Signed byte load, ready on second ACCESS cycle, rvalid one cycle later
      set_op(32'h44, 32'h103, 32'h0, 2'b01, 2'b00, 1'b1, 5'd7);
      step();
      set_bubble();
      check_eq("lb_stall", 32'(stall), 32'd1);
      check_eq("lb_req", 32'(mem_if.mem_req), 32'd1);
      check_eq("lb_addr", mem_if.mem_addr, 32'h100);
      check_eq("lb_wstrb", 32'(mem_if.mem_wstrb), 32'd0);
      check_eq("lb_we", 32'(mem_if.mem_we), 32'd0);
      check_eq("lb_wbt_bubble", 32'(write_back_type_output), 32'(WB_HICCUP));
      step();
      check_eq("lb_req_held", 32'(mem_if.mem_req), 32'd1);
      mem_if.mem_ready = 1'b1;
      step();
      mem_if.mem_ready = 1'b0;
      check_eq("lb_wait_req", 32'(mem_if.mem_req), 32'd0);
      check_eq("lb_wait_stall", 32'(stall), 32'd1);
      mem_if.mem_rvalid = 1'b1;
      mem_if.mem_rdata  = 32'h80FF_0000;
      step();
      mem_if.mem_rvalid = 1'b0;
      mem_if.mem_rdata  = 32'h0;
      check_eq("lb_complete_stall", 32'(stall), 32'd1);
      step();
      check_eq("lb_done_stall", 32'(stall), 32'd0);
      check_eq("lb_wbv", write_back_value, 32'hFFFF_FF80);
      check_eq("lb_rd", 32'(destination_register_number_output), 32'd7);
      check_eq("lb_wbt", 32'(write_back_type_output), 32'(WB_NORMAL));
      check_eq("lb_pc", pc_output, 32'h44);
      check_eq("lb_fwd_en", 32'(forward_enable), 32'd1);

      // Half store with ready already high
      set_op(32'h48, 32'h102, 32'hAAAA_BEEF, 2'b00, 2'b10, 1'b0, 5'd0);
      mem_if.mem_ready = 1'b1;
      step();
      set_bubble();
      check_eq("sh_req", 32'(mem_if.mem_req), 32'd1);
      check_eq("sh_we", 32'(mem_if.mem_we), 32'd1);
      check_eq("sh_wdata", mem_if.mem_wdata, 32'hBEEF_BEEF);
      check_eq("sh_wstrb", 32'(mem_if.mem_wstrb), 32'hC);
      check_eq("sh_addr", mem_if.mem_addr, 32'h100);
      step();
      mem_if.mem_ready = 1'b0;
      check_eq("sh_complete_req", 32'(mem_if.mem_req), 32'd0);
      step();
      check_eq("sh_stall", 32'(stall), 32'd0);
      check_eq("sh_wbv", write_back_value, 32'h102);
      check_eq("sh_wbt", 32'(write_back_type_output), 32'(WB_NORMAL));
      check_eq("sh_fwd_en", 32'(forward_enable), 32'd0);

      // Unsigned half load, ready and rvalid together: minimum latency
      set_op(32'h4C, 32'h2, 32'h0, 2'b10, 2'b00, 1'b0, 5'd9);
      step();
      set_bubble();
      mem_if.mem_ready  = 1'b1;
      mem_if.mem_rvalid = 1'b1;
      mem_if.mem_rdata  = 32'hBEEF_1234;
      step();
      mem_if.mem_ready  = 1'b0;
      mem_if.mem_rvalid = 1'b0;
      mem_if.mem_rdata  = 32'h0;
      check_eq("lhu_complete_stall", 32'(stall), 32'd1);
      step();
      check_eq("lhu_stall", 32'(stall), 32'd0);
      check_eq("lhu_wbv", write_back_value, 32'h0000_BEEF);

      // Misaligned word load
      set_op(32'h50, 32'h101, 32'h0, 2'b11, 2'b00, 1'b0, 5'd3);
      step();
      set_bubble();
      check_eq("mis_pulse", 32'(misaligned), 32'd1);
      check_eq("mis_wbt", 32'(write_back_type_output), 32'(WB_HICCUP));
      check_eq("mis_req", 32'(mem_if.mem_req), 32'd0);
      check_eq("mis_stall", 32'(stall), 32'd0);
      check_eq("mis_fwd_en", 32'(forward_enable), 32'd0);
      step();
      check_eq("mis_pulse_end", 32'(misaligned), 32'd0);

      // Timeout with mem_ready held low
      set_op(32'h54, 32'h200, 32'h0, 2'b11, 2'b00, 1'b0, 5'd4);
      step();
      set_bubble();
      for (int i = 0; i < 3; i++) begin
         step();
         check_eq("to_pending_stall", 32'(stall), 32'd1);
         check_eq("to_pending_berr", 32'(bus_error), 32'd0);
      end
      step();
      check_eq("to_berr", 32'(bus_error), 32'd1);
      check_eq("to_stall", 32'(stall), 32'd0);
      check_eq("to_req", 32'(mem_if.mem_req), 32'd0);
      check_eq("to_wbt", 32'(write_back_type_output), 32'(WB_HICCUP));
      step();
      check_eq("to_berr_end", 32'(bus_error), 32'd0);

      // Reset asserted in WAIT_DATA, then a stray rvalid
      set_op(32'h58, 32'h300, 32'h0, 2'b01, 2'b00, 1'b0, 5'd6);
      step();
      set_bubble();
      mem_if.mem_ready = 1'b1;
      step();
      mem_if.mem_ready = 1'b0;
      check_eq("rst_wait_stall", 32'(stall), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      check_eq("rst_mid_stall", 32'(stall), 32'd0);
      check_eq("rst_mid_req", 32'(mem_if.mem_req), 32'd0);
      check_eq("rst_mid_wbt", 32'(write_back_type_output), 32'(WB_HICCUP));
      check_eq("rst_mid_wbv", write_back_value, 32'h0);
      #1;
      reset = 1'b0;
      mem_if.mem_rvalid = 1'b1;
      mem_if.mem_rdata  = 32'h1234_5678;
      step();
      mem_if.mem_rvalid = 1'b0;
      mem_if.mem_rdata  = 32'h0;
      check_eq("late_rvalid_stall", 32'(stall), 32'd0);
      check_eq("late_rvalid_wbt", 32'(write_back_type_output), 32'(WB_HICCUP));
      step();
      check_eq("late_rvalid_wbv", write_back_value, 32'h0);
      check_eq("late_rvalid_fwd_en", 32'(forward_enable), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
